alu_seq: RTL and testbench

Parametrised, handshaked successor to the 3-bit-opcode combinational ALU. It keeps the eight single-cycle operations on the same opcode values and adds status flags. It adds iterative multi-cycle unsigned multiply and variable shifts, and registers the result behind valid/ready handshakes. It sits between the operand-fetch stage and writeback in the datapath, accepting one operation at a time.

---
 rtl/alu_seq_if.sv | 31 +++
 rtl/alu_seq.sv | 163 ++++++++++++++++
 tb/tb_alu_seq.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_if.sv
// Request/response bundle for alu_seq: request handshake with opcode and
// operands, plus result handshake with result and status flags.
interface alu_seq_if #(
  parameter int W = 32
);
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   F;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] R;
  logic         Z;
  logic         N;
  logic         C;
  logic         V;
  logic         ERR;

  // Operand-fetch side / consumer side (drives requests, takes results)
  modport master (
    output in_valid, F, A, B, out_ready,
    input  in_ready, out_valid, R, Z, N, C, V, ERR
  );

  // ALU side
  modport slave (
    input  in_valid, F, A, B, out_ready,
    output in_ready, out_valid, R, Z, N, C, V, ERR
  );
endinterface

// File: rtl/alu_seq.sv
// Handshaked ALU: eight single-cycle legacy ops, iterative shift-add
// multiply (W steps) and bit-serial shifts (k steps), registered result
// and flags held until the consumer takes them.
module alu_seq #(
  parameter int W = 32
) (
  input  logic     clk,
  input  logic     rst_n,
  alu_seq_if.slave bus
);
  localparam int SW = $clog2(W);
  localparam logic [SW:0] CNT_MUL = (SW+1)'(W);
  localparam logic [SW:0] CNT_ONE = (SW+1)'(1);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_XNOR = 4'b0100;
  localparam logic [3:0] OP_NOTA = 4'b0101;
  localparam logic [3:0] OP_PASS = 4'b0110;
  localparam logic [3:0] OP_NOTB = 4'b0111;
  localparam logic [3:0] OP_SLL  = 4'b1010;
  localparam logic [3:0] OP_SRA  = 4'b1011;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t         r_state, w_state_nxt;
  logic [1:0]     r_op;      // low opcode bits of the running multi-cycle op
  logic [W-1:0]   r_a;       // multiplicand
  logic [2*W-1:0] r_acc;     // {partial product, multiplier} or shift value in low half
  logic [SW:0]    r_cnt;
  logic [W-1:0]   r_r;
  logic           r_z, r_n, r_c, r_v, r_err;

  logic           w_accept, w_is_multi, w_is_mul, w_go_busy, w_last;
  logic [SW-1:0]  w_shamt;
  logic [W-1:0]   w_b_eff;
  logic [W:0]     w_sum;
  logic [W-1:0]   w_imm_r;
  logic           w_imm_c, w_imm_v, w_imm_err;
  logic [W:0]     w_mul_sum;
  logic [2*W-1:0] w_step;
  logic [W-1:0]   w_fin_r;

  assign w_accept   = (r_state == S_IDLE) && bus.in_valid;
  assign w_is_multi = (bus.F[3:2] == 2'b10);
  assign w_is_mul   = w_is_multi && !bus.F[1];
  assign w_shamt    = bus.B[SW-1:0];
  // A zero-amount shift needs no iteration and completes like a single-cycle op
  assign w_go_busy  = w_is_mul || (w_is_multi && (w_shamt != '0));
  assign w_last     = (r_state == S_BUSY) && (r_cnt == CNT_ONE);

  // SUB reuses the adder as A + ~B + 1
  assign w_b_eff = (bus.F == OP_SUB) ? ~bus.B : bus.B;
  assign w_sum   = {1'b0, bus.A} + {1'b0, w_b_eff} + {{W{1'b0}}, (bus.F == OP_SUB)};

  // Single-cycle result and arithmetic flags straight from the bus operands
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred
    w_imm_r   = '0;
    w_imm_c   = 1'b0;
    w_imm_v   = 1'b0;
    w_imm_err = 1'b0;
    case (bus.F)
      OP_ADD, OP_SUB: begin
        w_imm_r = w_sum[W-1:0];
        w_imm_c = w_sum[W];
        w_imm_v = (bus.A[W-1] == w_b_eff[W-1]) && (w_sum[W-1] != bus.A[W-1]);
      end
      OP_AND:         w_imm_r = bus.A & bus.B;
      OP_OR:          w_imm_r = bus.A | bus.B;
      OP_XNOR:        w_imm_r = ~(bus.A ^ bus.B);
      OP_NOTA:        w_imm_r = ~bus.A;
      OP_PASS:        w_imm_r = bus.A;
      OP_NOTB:        w_imm_r = ~bus.B;
      OP_SLL, OP_SRA: w_imm_r = bus.A;   // only reached with shift amount 0
      default:        w_imm_err = (bus.F[3:2] == 2'b11);
    endcase
  end

  // One iteration step: shift-add for multiply, one-bit shift otherwise
  always_comb begin
    w_mul_sum = {1'b0, r_acc[2*W-1:W]} + (r_acc[0] ? {1'b0, r_a} : '0);
    w_step    = {w_mul_sum, r_acc[W-1:1]};
    if (r_op[1]) begin
      if (r_op[0]) w_step = {r_acc[2*W-1:W], r_acc[W-1], r_acc[W-1:1]};
      else         w_step = {r_acc[2*W-1:W], r_acc[W-2:0], 1'b0};
    end
    w_fin_r = (r_op == 2'b01) ? w_step[2*W-1:W] : w_step[W-1:0];
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (bus.in_valid) w_state_nxt = w_go_busy ? S_BUSY : S_DONE;
      S_BUSY:  if (w_last)       w_state_nxt = S_DONE;
      S_DONE:  if (bus.out_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from state
  always_comb begin
    bus.in_ready  = (r_state == S_IDLE);
    bus.out_valid = (r_state == S_DONE);
  end

  // Operand capture, iteration and result/flag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op  <= '0;
      r_a   <= '0;
      r_acc <= '0;
      r_cnt <= '0;
      r_r   <= '0;
      r_z   <= 1'b0;
      r_n   <= 1'b0;
      r_c   <= 1'b0;
      r_v   <= 1'b0;
      r_err <= 1'b0;
    end else if (w_accept) begin
      r_op  <= bus.F[1:0];
      r_a   <= bus.A;
      r_acc <= {{W{1'b0}}, (w_is_mul ? bus.B : bus.A)};
      r_cnt <= w_is_mul ? CNT_MUL : (w_is_multi ? {1'b0, w_shamt} : '0);
      if (!w_go_busy) begin
        r_r   <= w_imm_r;
        r_z   <= (w_imm_r == '0);
        r_n   <= w_imm_r[W-1];
        r_c   <= w_imm_c;
        r_v   <= w_imm_v;
        r_err <= w_imm_err;
      end
    end else if (r_state == S_BUSY) begin
      r_acc <= w_step;
      r_cnt <= r_cnt - CNT_ONE;
      if (w_last) begin
        r_r   <= w_fin_r;
        r_z   <= (w_fin_r == '0);
        r_n   <= w_fin_r[W-1];
        r_c   <= 1'b0;
        r_v   <= 1'b0;
        r_err <= 1'b0;
      end
    end
  end

  assign bus.R   = r_r;
  assign bus.Z   = r_z;
  assign bus.N   = r_n;
  assign bus.C   = r_c;
  assign bus.V   = r_v;
  assign bus.ERR = r_err;
endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed corner cases, random operations
// against an arithmetic reference model, backpressure and mid-op reset.
module tb_alu_seq;
  localparam int W = 32;

  typedef struct packed {
    logic [31:0] r;
    logic        z, n, c, v, err;
  } res_t;

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  alu_seq_if #(.W(W)) bus ();

  alu_seq #(.W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: results from plain integer arithmetic on the opcode's meaning
  function automatic res_t model(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b);
    res_t               m;
    logic [32:0]        s;
    logic [63:0]        p;
    longint             sr;
    logic signed [31:0] as_v;
    int                 k;
    m    = '0;
    as_v = a;
    p    = {32'b0, a} * {32'b0, b};
    k    = int'(b[4:0]);
    case (f)
      4'd0: begin
        s   = {1'b0, a} + {1'b0, b};
        m.r = s[31:0];
        m.c = s[32];
        sr  = longint'($signed(a)) + longint'($signed(b));
        m.v = (sr != longint'($signed(sr[31:0])));
      end
      4'd1: begin
        m.r = a - b;
        m.c = (a >= b);
        sr  = longint'($signed(a)) - longint'($signed(b));
        m.v = (sr != longint'($signed(sr[31:0])));
      end
      4'd2:  m.r = a & b;
      4'd3:  m.r = a | b;
      4'd4:  m.r = ~(a ^ b);
      4'd5:  m.r = ~a;
      4'd6:  m.r = a;
      4'd7:  m.r = ~b;
      4'd8:  m.r = p[31:0];
      4'd9:  m.r = p[63:32];
      4'd10: m.r = a << k;
      4'd11: m.r = as_v >>> k;
      default: m.err = 1'b1;
    endcase
    m.z = (m.r == 32'd0);
    m.n = m.r[31];
    return m;
  endfunction

  // Edges after the accept edge until out_valid is seen
  function automatic int model_lat(input logic [3:0] f, input logic [31:0] b);
    if (f[3:2] != 2'b10) return 0;
    if (!f[1])           return W;
    return int'(b[4:0]);
  endfunction

  task automatic issue(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    check("in_ready_before_accept", 64'(bus.in_ready), 64'd1);
    bus.in_valid = 1'b1;
    bus.F = f;
    bus.A = a;
    bus.B = b;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    // Operands wander while the op runs; the ALU must have latched its own copy
    bus.F = 4'($urandom);
    bus.A = $urandom;
    bus.B = $urandom;
    check("in_ready_after_accept", 64'(bus.in_ready), 64'd0);
  endtask

  task automatic do_op(input string tag, input logic [3:0] f, input logic [31:0] a,
                       input logic [31:0] b, input int hold);
    res_t m;
    int   lat;
    m = model(f, a, b);
    issue(f, a, b);
    lat = 0;
    while (!bus.out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, "_latency"}, 64'(lat), 64'(model_lat(f, b)));
    check({tag, "_R"}, 64'(bus.R), 64'(m.r));
    check({tag, "_flags_ZNCVE"}, 64'({bus.Z, bus.N, bus.C, bus.V, bus.ERR}),
          64'({m.z, m.n, m.c, m.v, m.err}));
    check({tag, "_in_ready_in_done"}, 64'(bus.in_ready), 64'd0);
    for (int i = 0; i < hold; i++) begin
      bus.in_valid = 1'b1;
      bus.F = 4'($urandom);
      bus.A = $urandom;
      bus.B = $urandom;
      @(posedge clk);
      #1;
      check({tag, "_hold_R"}, 64'(bus.R), 64'(m.r));
      check({tag, "_hold_flags"}, 64'({bus.Z, bus.N, bus.C, bus.V, bus.ERR}),
            64'({m.z, m.n, m.c, m.v, m.err}));
      check({tag, "_hold_valid_ready"}, 64'({bus.out_valid, bus.in_ready}), 64'b10);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check({tag, "_release_valid_ready"}, 64'({bus.out_valid, bus.in_ready}), 64'b01);
  endtask

  initial begin
    logic [3:0]  rf;
    logic [31:0] ra, rb;
    rst_n         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.F         = '0;
    bus.A         = '0;
    bus.B         = '0;
    #2 rst_n = 1'b0;
    #1;
    check("reset_in_ready", 64'(bus.in_ready), 64'd1);
    check("reset_outputs", 64'({bus.out_valid, bus.R, bus.Z, bus.N, bus.C, bus.V, bus.ERR}), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    // Directed corners
    do_op("add_wrap",    4'b0000, 32'hFFFF_FFFF, 32'd1,         0);
    do_op("sub_ovf",     4'b0001, 32'h8000_0000, 32'd1,         0);
    do_op("sub_borrow",  4'b0001, 32'd1,         32'd2,         0);
    do_op("add_ovf",     4'b0000, 32'h7FFF_FFFF, 32'd1,         0);
    do_op("mullo",       4'b1000, 32'h0001_0000, 32'h0001_0000, 0);
    do_op("mulhi",       4'b1001, 32'h0001_0000, 32'h0001_0000, 0);
    do_op("mulhi_max",   4'b1001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    do_op("sra4",        4'b1011, 32'h8000_0000, 32'd4,         0);
    do_op("sll31",       4'b1010, 32'd1,         32'd31,        0);
    do_op("sll0",        4'b1010, 32'h1234_5678, 32'h20,        0);
    do_op("xnor",        4'b0100, 32'hF0F0_1234, 32'h0FF0_1234, 0);
    do_op("illegal",     4'b1100, 32'hDEAD_BEEF, 32'h1234_5678, 0);
    do_op("backpressure",4'b0001, 32'd10,        32'd3,         5);

    // Random operations across all opcodes, then extra random multiplies
    for (int i = 0; i < 24; i++) begin
      rf = 4'($urandom_range(0, 15));
      ra = $urandom;
      rb = $urandom;
      do_op("rand_op", rf, ra, rb, int'($urandom_range(0, 2)));
    end
    for (int i = 0; i < 6; i++) begin
      rf = (i % 2 == 0) ? 4'b1000 : 4'b1001;
      ra = $urandom;
      rb = $urandom;
      do_op("rand_mul", rf, ra, rb, 0);
    end

    // Reset in the middle of a multiply aborts it
    issue(4'b1000, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (9) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort_in_ready", 64'(bus.in_ready), 64'd1);
    check("abort_outputs", 64'({bus.out_valid, bus.R, bus.Z, bus.N, bus.C, bus.V, bus.ERR}), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    repeat (40) begin
      @(posedge clk);
      #1;
      check("abort_no_stale_valid", 64'({bus.out_valid, bus.in_ready}), 64'b01);
    end
    do_op("add_after_reset", 4'b0000, 32'd2, 32'd3, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
